// File: rtl/uop_pkg.sv
// Shared types and constants for the L0 line supplier front end.
package uop_pkg;

  localparam int SUPER_SCALAR_WIDTH = 4;
  localparam int GROUP_BYTES        = 4 * SUPER_SCALAR_WIDTH;
  localparam int LINE_BYTES         = 64;

  typedef logic [LINE_BYTES-1:0][7:0] l0_line_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    DROP      = 2'd3
  } l0_state_e;

endpackage

// File: rtl/l0_tag_array.sv
// Fully-associative L0 line store: combinational lookup plus a FIFO-ordered
// install port that reuses an entry when the incoming tag is already present.
module l0_tag_array #(
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 4,
  parameter int TAG_W      = 58
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [TAG_W-1:0]           lookup_tag_in,
  output logic                       hit_out,
  output logic [LINE_BYTES-1:0][7:0] hit_line_out,
  input  logic                       install_en_in,
  input  logic [TAG_W-1:0]           install_tag_in,
  input  logic [LINE_BYTES-1:0][7:0] install_line_in
);

  localparam int IDX_W = $clog2(NUM_LINES);

  logic [TAG_W-1:0]           tag_q  [NUM_LINES];
  logic [TAG_W-1:0]           tag_d  [NUM_LINES];
  logic [LINE_BYTES-1:0][7:0] data_q [NUM_LINES];
  logic [LINE_BYTES-1:0][7:0] data_d [NUM_LINES];
  logic [NUM_LINES-1:0]       valid_q, valid_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;

  logic                       lk_hit;
  logic [LINE_BYTES-1:0][7:0] lk_line;
  logic                       dup_hit;
  logic [IDX_W-1:0]           dup_idx;
  logic [IDX_W-1:0]           victim;

  always_comb begin
    lk_hit  = 1'b0;
    lk_line = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!lk_hit && valid_q[i] && (tag_q[i] == lookup_tag_in)) begin
        lk_hit  = 1'b1;
        lk_line = data_q[i];
      end
    end
  end

  assign hit_out      = lk_hit;
  assign hit_line_out = lk_line;

  // A refill of a tag already resident overwrites in place so no duplicate
  // entries can exist; the FIFO pointer only moves on a fresh allocation.
  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!dup_hit && valid_q[i] && (tag_q[i] == install_tag_in)) begin
        dup_hit = 1'b1;
        dup_idx = IDX_W'(i);
      end
    end
    victim = dup_hit ? dup_idx : ptr_q;
  end

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (install_en_in) begin
      tag_d[victim]   = install_tag_in;
      data_d[victim]  = install_line_in;
      valid_d[victim] = 1'b1;
      if (!dup_hit) begin
        ptr_d = ptr_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: rtl/l0_line_supplier.sv
// Walks a sequential fetch PC, serves lines from the L0 buffer on a hit and
// runs the L1i miss request/fill sequence otherwise.
module l0_line_supplier
  import uop_pkg::*;
#(
  parameter int          CACHE_LINE_WIDTH   = 64,
  parameter int          NUM_LINES          = 4,
  parameter int          SUPER_SCALAR_WIDTH = uop_pkg::SUPER_SCALAR_WIDTH,
  parameter logic [63:0] RESET_PC           = 64'h0
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             flush_in,
  input  logic [63:0]                      flush_pc_in,
  input  logic                             fetch_ready_in,
  output logic [CACHE_LINE_WIDTH-1:0][7:0] l0_cacheline_out,
  output logic                             bp_l0_valid_out,
  output logic                             pc_valid_out,
  output logic [63:0]                      pred_pc_out,
  output logic                             l1i_req_valid_out,
  output logic [63:0]                      l1i_req_addr_out,
  input  logic                             l1i_req_ready_in,
  input  logic                             l1i_resp_valid_in,
  input  logic [CACHE_LINE_WIDTH-1:0][7:0] l1i_resp_line_in,
  output l0_state_e                        state_dbg_out
);

  localparam int          BOB       = $clog2(CACHE_LINE_WIDTH);
  localparam int          TAG_W     = 64 - BOB;
  localparam int          GRP_BYTES = 4 * SUPER_SCALAR_WIDTH;
  localparam logic [BOB:0] GRP_OFF  = (BOB+1)'(GRP_BYTES);
  localparam logic [BOB:0] LINE_END = (BOB+1)'(CACHE_LINE_WIDTH);

  // Groups never straddle a line: a group that would run past the end of the
  // line is followed by the next line base rather than pc + GROUP_BYTES.
  function automatic logic [63:0] seq_next(input logic [63:0] pc);
    logic [BOB:0]     off_sum;
    logic [TAG_W-1:0] tag_inc;
    off_sum = {1'b0, pc[BOB-1:0]} + GRP_OFF;
    tag_inc = pc[63:BOB] + TAG_W'(1);
    if (off_sum >= LINE_END) begin
      seq_next = {tag_inc, {BOB{1'b0}}};
    end else begin
      seq_next = pc + 64'(GRP_BYTES);
    end
  endfunction

  l0_state_e                        state_q, state_d;
  logic [63:0]                      pc_q, pc_d;
  logic [CACHE_LINE_WIDTH-1:0][7:0] line_q, line_d;
  logic                             bp_valid_q, bp_valid_d;
  logic                             pc_valid_q, pc_valid_d;
  logic [63:0]                      pred_pc_q, pred_pc_d;
  logic                             req_valid_q, req_valid_d;
  logic [63:0]                      req_addr_q, req_addr_d;

  logic                             hit;
  logic [CACHE_LINE_WIDTH-1:0][7:0] hit_line;
  logic                             install_en;

  l0_tag_array #(
    .LINE_BYTES (CACHE_LINE_WIDTH),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TAG_W)
  ) u_tag_array (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .lookup_tag_in   (pc_q[63:BOB]),
    .hit_out         (hit),
    .hit_line_out    (hit_line),
    .install_en_in   (install_en),
    .install_tag_in  (req_addr_q[63:BOB]),
    .install_line_in (l1i_resp_line_in)
  );

  // L1i request handshake: the request transfers on a cycle where both
  // l1i_req_valid_out and l1i_req_ready_in are high; while valid is high and
  // not yet accepted, the address is held stable. Responses carry no
  // handshake and are only honoured in MISS_WAIT or DROP.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    line_d      = line_q;
    bp_valid_d  = 1'b0;
    pc_valid_d  = 1'b0;
    pred_pc_d   = pred_pc_q;
    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    install_en  = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_in) begin
          pc_d = flush_pc_in;
        end else if (fetch_ready_in) begin
          pc_valid_d = 1'b1;
          pred_pc_d  = pc_q;
          if (hit) begin
            bp_valid_d = 1'b1;
            line_d     = hit_line;
            pc_d       = seq_next(pc_q);
          end else begin
            req_valid_d = 1'b1;
            req_addr_d  = {pc_q[63:BOB], {BOB{1'b0}}};
            state_d     = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        if (flush_in) begin
          pc_d    = flush_pc_in;
          state_d = l1i_req_ready_in ? DROP : RUN;
        end else if (l1i_req_ready_in) begin
          state_d = MISS_WAIT;
        end else begin
          req_valid_d = 1'b1;
        end
      end
      MISS_WAIT: begin
        if (l1i_resp_valid_in) begin
          install_en = 1'b1;
          state_d    = RUN;
          pc_d       = flush_in ? flush_pc_in : seq_next(pc_q);
        end else if (flush_in) begin
          pc_d    = flush_pc_in;
          state_d = DROP;
        end
      end
      DROP: begin
        // The outstanding fill is still installed, but fetch no longer wants
        // that group, so pc is left at the redirect target.
        if (l1i_resp_valid_in) begin
          install_en = 1'b1;
          state_d    = RUN;
        end
        if (flush_in) begin
          pc_d = flush_pc_in;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      line_q      <= '0;
      bp_valid_q  <= 1'b0;
      pc_valid_q  <= 1'b0;
      pred_pc_q   <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      line_q      <= line_d;
      bp_valid_q  <= bp_valid_d;
      pc_valid_q  <= pc_valid_d;
      pred_pc_q   <= pred_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign l0_cacheline_out  = line_q;
  assign bp_l0_valid_out   = bp_valid_q;
  assign pc_valid_out      = pc_valid_q;
  assign pred_pc_out       = pred_pc_q;
  assign l1i_req_valid_out = req_valid_q;
  assign l1i_req_addr_out  = req_addr_q;
  assign state_dbg_out     = state_q;

endmodule

// File: tb/tb_l0_line_supplier.sv
// Directed bench for l0_line_supplier: expected fetch pulses are queued as
// stimulus is issued and a negedge monitor pops and compares them.
module tb_l0_line_supplier;
  import uop_pkg::*;

  localparam int LW = LINE_BYTES;
  typedef logic [LW-1:0][7:0] line_t;

  typedef struct packed {
    logic        bp;
    logic [63:0] pc;
    logic        req;
    logic [63:0] addr;
    line_t       line;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        flush_in = 1'b0;
  logic [63:0] flush_pc_in = '0;
  logic        fetch_ready_in = 1'b0;
  line_t       l0_cacheline_out;
  logic        bp_l0_valid_out;
  logic        pc_valid_out;
  logic [63:0] pred_pc_out;
  logic        l1i_req_valid_out;
  logic [63:0] l1i_req_addr_out;
  logic        l1i_req_ready_in = 1'b0;
  logic        l1i_resp_valid_in = 1'b0;
  line_t       l1i_resp_line_in = '0;
  l0_state_e   state_dbg_out;

  l0_line_supplier #(
    .CACHE_LINE_WIDTH   (LW),
    .NUM_LINES          (4),
    .SUPER_SCALAR_WIDTH (4),
    .RESET_PC           (64'h0)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .flush_in          (flush_in),
    .flush_pc_in       (flush_pc_in),
    .fetch_ready_in    (fetch_ready_in),
    .l0_cacheline_out  (l0_cacheline_out),
    .bp_l0_valid_out   (bp_l0_valid_out),
    .pc_valid_out      (pc_valid_out),
    .pred_pc_out       (pred_pc_out),
    .l1i_req_valid_out (l1i_req_valid_out),
    .l1i_req_addr_out  (l1i_req_addr_out),
    .l1i_req_ready_in  (l1i_req_ready_in),
    .l1i_resp_valid_in (l1i_resp_valid_in),
    .l1i_resp_line_in  (l1i_resp_line_in),
    .state_dbg_out     (state_dbg_out)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic line_t line_for(input logic [63:0] a);
    line_t l;
    for (int i = 0; i < LW; i++) l[i] = 8'(i) ^ a[13:6] ^ 8'h5a;
    return l;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low64 0x%0h, expected low64 0x%0h", name, 64'(act), 64'(exp));
    end
  endtask

  task automatic push_miss(input logic [63:0] pc);
    exp_t e;
    e.bp = 1'b0; e.pc = pc; e.req = 1'b1; e.addr = {pc[63:6], 6'b0}; e.line = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_hit(input logic [63:0] pc);
    exp_t e;
    e.bp = 1'b1; e.pc = pc; e.req = 1'b0; e.addr = '0; e.line = line_for({pc[63:6], 6'b0});
    exp_q.push_back(e);
  endtask

  task automatic push_hits(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) push_hit(start + 64'(16 * i));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_req(input logic [63:0] a);
    int k;
    k = 0;
    @(negedge clk_in);
    while (!l1i_req_valid_out && k < 60) begin
      @(negedge clk_in);
      k++;
    end
    check64("req_seen", 64'(l1i_req_valid_out), 64'd1);
    check64("req_addr_wait", l1i_req_addr_out, a);
  endtask

  task automatic accept(input int d, input logic [63:0] a);
    for (int i = 0; i < d; i++) begin
      @(negedge clk_in);
      check64("req_held_valid", 64'(l1i_req_valid_out), 64'd1);
      check64("req_held_addr", l1i_req_addr_out, a);
    end
    l1i_req_ready_in = 1'b1;
    @(negedge clk_in);
    l1i_req_ready_in = 1'b0;
  endtask

  task automatic respond(input logic [63:0] a, input int d);
    repeat (d) @(negedge clk_in);
    l1i_resp_valid_in = 1'b1;
    l1i_resp_line_in  = line_for(a);
    @(negedge clk_in);
    l1i_resp_valid_in = 1'b0;
  endtask

  task automatic serve(input logic [63:0] a);
    accept(0, a);
    respond(a, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (!rst_in) begin
      if (bp_l0_valid_out) check64("bp_implies_pc_valid", 64'(pc_valid_out), 64'd1);
      if (pc_valid_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: pred_pc 0x%0h with nothing expected", pred_pc_out);
        end else begin
          e = exp_q.pop_front();
          check64("pred_pc", pred_pc_out, e.pc);
          check64("bp_valid", 64'(bp_l0_valid_out), 64'(e.bp));
          check64("req_valid_with_pulse", 64'(l1i_req_valid_out), 64'(e.req));
          if (e.req) check64("req_addr", l1i_req_addr_out, e.addr);
          if (e.bp) check_line("hit_line", l0_cacheline_out, e.line);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk_in);
    check64("rst_pc_valid", 64'(pc_valid_out), 64'd0);
    check64("rst_bp_valid", 64'(bp_l0_valid_out), 64'd0);
    check64("rst_req_valid", 64'(l1i_req_valid_out), 64'd0);
    check64("rst_req_addr", l1i_req_addr_out, 64'd0);
    check64("rst_pred_pc", pred_pc_out, 64'd0);
    check_line("rst_line", l0_cacheline_out, '0);
    check64("rst_state", 64'(state_dbg_out), 64'(RUN));

    // Cold miss at 0x0, slow accept, fill 3 cycles after accept.
    push_miss(64'h0);
    push_hits(64'h10, 3);
    push_miss(64'h40);
    rst_in = 1'b0;
    fetch_ready_in = 1'b1;
    wait_req(64'h0);
    accept(2, 64'h0);
    respond(64'h0, 2);

    // Flush while waiting for 0x40: fill lands silently, pc goes to 0x1000.
    wait_req(64'h40);
    push_miss(64'h1000);
    accept(0, 64'h40);
    flush_in = 1'b1;
    flush_pc_in = 64'h1000;
    @(negedge clk_in);
    flush_in = 1'b0;
    check64("drop_state", 64'(state_dbg_out), 64'(DROP));
    check64("drop_no_pc_valid", 64'(pc_valid_out), 64'd0);
    check64("drop_no_req", 64'(l1i_req_valid_out), 64'd0);
    respond(64'h40, 1);

    // Flush before the 0x1000 request is accepted: request withdrawn, 0x40 hits.
    wait_req(64'h1000);
    push_hits(64'h40, 4);
    push_miss(64'h80);
    flush_in = 1'b1;
    flush_pc_in = 64'h40;
    @(negedge clk_in);
    flush_in = 1'b0;
    check64("withdraw_req", 64'(l1i_req_valid_out), 64'd0);
    check64("withdraw_state", 64'(state_dbg_out), 64'(RUN));

    // Fill 0x80, 0xC0, 0x100; the 0x100 fill evicts 0x0 (oldest entry).
    wait_req(64'h80);
    push_hits(64'h90, 3);
    push_miss(64'hc0);
    serve(64'h80);
    wait_req(64'hc0);
    push_hits(64'hd0, 3);
    push_miss(64'h100);
    serve(64'hc0);
    wait_req(64'h100);
    push_hits(64'h110, 3);
    push_miss(64'h140);
    serve(64'h100);

    // Redirect to 0x78: hit in line 0x40, next group is 0x80 (line crossing).
    wait_req(64'h140);
    push_hit(64'h78);
    push_hits(64'h80, 12);
    push_miss(64'h140);
    flush_in = 1'b1;
    flush_pc_in = 64'h78;
    @(negedge clk_in);
    flush_in = 1'b0;

    // Flush in the same cycle the request is accepted: DROP, then 0x0 misses.
    wait_req(64'h140);
    push_miss(64'h0);
    flush_in = 1'b1;
    flush_pc_in = 64'h0;
    l1i_req_ready_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    l1i_req_ready_in = 1'b0;
    check64("accept_flush_state", 64'(state_dbg_out), 64'(DROP));
    respond(64'h140, 2);

    // Refill 0x0, then hold fetch off for 5 cycles after the 0x10 hit.
    wait_req(64'h0);
    push_hit(64'h10);
    accept(1, 64'h0);
    respond(64'h0, 1);
    @(negedge clk_in);
    fetch_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check64("stall_no_pc_valid", 64'(pc_valid_out), 64'd0);
      check64("stall_no_bp_valid", 64'(bp_l0_valid_out), 64'd0);
    end
    push_hits(64'h20, 2);
    push_miss(64'h40);
    fetch_ready_in = 1'b1;
    wait_req(64'h40);

    flush_in = 1'b1;
    flush_pc_in = 64'h0;
    fetch_ready_in = 1'b0;
    @(negedge clk_in);
    flush_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check64("final_state", 64'(state_dbg_out), 64'(RUN));
    check64("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
